// File: rtl/flitzip_pkg.sv
// Shared definitions for the base-delta flit compressor/decompressor.
// Pair layout, FSM encoding and code constants.
package flitzip_pkg;

  localparam int FLIT_WIDTH_DEF = 128;
  localparam int CHUNK_SIZE_DEF = 8;
  localparam int EN_BITS_DEF    = 3;
  localparam int NUM_PAIRS_DEF  = 4;

  localparam int CODE_RAW = 0;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } state_t;

  function automatic int pair_w(
    input int en_bits,
    input int chunk_size
  );
    return en_bits + chunk_size;
  endfunction

  // Pair 0 occupies the MSBs of the metadata field.
  function automatic int pair_msb(
    input int meta_w,
    input int pw,
    input int k
  );
    return meta_w - 1 - k * pw;
  endfunction

endpackage

// File: rtl/lane_decoder.sv
// One lane of base-delta decode: sign-extend the low
// code bits of the chunk, then subtract the base.
module lane_decoder
  import flitzip_pkg::*;
#(
  parameter int CHUNK_SIZE = 8,
  parameter int EN_BITS    = 3
) (
  input  logic [EN_BITS-1:0]    code,
  input  logic [CHUNK_SIZE-1:0] base,
  input  logic [CHUNK_SIZE-1:0] chunk,
  output logic [CHUNK_SIZE-1:0] result
);

  localparam logic [EN_BITS-1:0] RAW = EN_BITS'(CODE_RAW);

  logic [CHUNK_SIZE-1:0] mask;
  logic [CHUNK_SIZE-1:0] top;
  logic [CHUNK_SIZE-1:0] xs;
  logic                  sgn;

  always_comb begin
    mask   = (CHUNK_SIZE'(1) << code) - CHUNK_SIZE'(1);
    top    = mask ^ (mask >> 1);
    sgn    = |(chunk & top);
    xs     = sgn ? (chunk | ~mask) : (chunk & mask);
    result = chunk;
    if (code == RAW) begin
      result = chunk;
    end else if (32'(code) < CHUNK_SIZE) begin
      result = xs - base;
    end else begin
      result = chunk - base;
    end
  end

endmodule

// File: rtl/flit_decompressor_pipe.sv
// Streaming base-delta flit decompressor with packet
// tracking, error flagging and a 1-deep output register.
module flit_decompressor_pipe
  import flitzip_pkg::*;
#(
  parameter int FLIT_WIDTH = FLIT_WIDTH_DEF,
  parameter int CHUNK_SIZE = CHUNK_SIZE_DEF,
  parameter int EN_BITS    = EN_BITS_DEF,
  parameter int NUM_PAIRS  = NUM_PAIRS_DEF
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  is_head,
  input  logic                  is_tail,
  input  logic [FLIT_WIDTH-1:0] data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic                  out_is_head,
  output logic                  out_is_tail,
  output logic                  err_flag
);

  localparam int NUM_CHUNKS = FLIT_WIDTH / CHUNK_SIZE;
  localparam int PW = pair_w(EN_BITS, CHUNK_SIZE);
  localparam int MW = NUM_PAIRS * PW;
  localparam int IW = $clog2(NUM_PAIRS + 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_PAIRS);

  state_t                state;
  state_t                state_n;
  logic [MW-1:0]         meta;
  logic [MW-1:0]         meta_n;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_n;
  logic                  accept;
  logic                  overrun;
  logic [PW-1:0]         pair;
  logic [EN_BITS-1:0]    code;
  logic [CHUNK_SIZE-1:0] base;
  logic [FLIT_WIDTH-1:0] dec;
  logic [FLIT_WIDTH-1:0] res_data;
  logic                  res_err;

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign overrun  = idx >= IDX_MAX;

  always_comb begin
    pair = '0;
    for (int k = 0; k < NUM_PAIRS; k++) begin
      if (idx == IW'(k)) begin
        pair = meta[pair_msb(MW, PW, k) -: PW];
      end
    end
  end

  assign code = pair[PW-1 -: EN_BITS];
  assign base = pair[CHUNK_SIZE-1:0];

  for (genvar g = 0; g < NUM_CHUNKS; g++) begin : g_lane
    lane_decoder #(
      .CHUNK_SIZE(CHUNK_SIZE),
      .EN_BITS   (EN_BITS)
    ) u_lane (
      .code  (code),
      .base  (base),
      .chunk (data_in[g*CHUNK_SIZE +: CHUNK_SIZE]),
      .result(dec[g*CHUNK_SIZE +: CHUNK_SIZE])
    );
  end

  always_comb begin
    state_n  = state;
    meta_n   = meta;
    idx_n    = idx;
    res_data = data_in;
    res_err  = 1'b0;
    unique case (1'b1)
      is_head: begin
        meta_n  = data_in[FLIT_WIDTH-1 -: MW];
        idx_n   = '0;
        res_err = (state == BODY);
        state_n = is_tail ? IDLE : BODY;
      end
      !is_head && state == IDLE: begin
        res_err = 1'b1;
      end
      !is_head && state == BODY: begin
        if (overrun) begin
          res_err = 1'b1;
        end else begin
          res_data = dec;
          idx_n    = idx + 1'b1;
        end
        if (is_tail) begin
          state_n = IDLE;
          idx_n   = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      meta  <= '0;
      idx   <= '0;
    end else if (accept) begin
      state <= state_n;
      meta  <= meta_n;
      idx   <= idx_n;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      out_valid   <= 1'b0;
      data_out    <= '0;
      out_is_head <= 1'b0;
      out_is_tail <= 1'b0;
      err_flag    <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        data_out    <= res_data;
        out_is_head <= is_head;
        out_is_tail <= is_tail;
        err_flag    <= res_err;
      end
    end
  end

endmodule
